// File: rtl/reloj_hms.sv
// reloj_hms: real-time timebase. A prescaler divides clk down to a one-cycle
// seconds tick that advances cascaded sec/min/hr counters, up or down.
// Also provides run/pause, synchronous clear, a validated time load and an
// alarm-match pulse. Every output comes straight from a register.
module reloj_hms #(
    parameter int CLK_DIV  = 50,  // clk cycles per seconds tick (>= 2)
    parameter int HOUR_MOD = 24   // hour modulus (2..32)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clr,
    input  logic       dir,
    input  logic       load,
    input  logic [5:0] load_sec,
    input  logic [5:0] load_min,
    input  logic [4:0] load_hr,
    input  logic       alarm_en,
    input  logic [5:0] alarm_sec,
    input  logic [5:0] alarm_min,
    input  logic [4:0] alarm_hr,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic       tick_sec,
    output logic       alarm,
    output logic       load_err
);

    localparam int            PW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [5:0]    SEC_MAX   = 6'd59;
    localparam logic [5:0]    MIN_MAX   = 6'd59;
    localparam logic [4:0]    HR_MAX    = 5'(HOUR_MOD - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hr_q, hr_d;
    logic          tick_q, tick_d;
    logic          alarm_q, alarm_d;
    logic          err_q, err_d;

    // Time the counters would show after one tick in the current direction.
    logic [5:0]    cnt_sec, cnt_min;
    logic [4:0]    cnt_hr;
    logic          tick_int;
    logic          load_ok;
    logic          alarm_hit;

    assign tick_int  = run && (presc_q == PRESC_MAX);
    assign load_ok   = (load_sec <= SEC_MAX) && (load_min <= MIN_MAX) && (load_hr <= HR_MAX);
    // An out-of-range alarm time can never equal a legal counter value.
    assign alarm_hit = (cnt_sec == alarm_sec) && (cnt_min == alarm_min) && (cnt_hr == alarm_hr);

    // One-step increment/decrement of the h:m:s cascade with carry/borrow.
    always_comb begin
        // NOTE: every output gets a default up front so no path leaves one unassigned (no latch).
        cnt_sec = sec_q;
        cnt_min = min_q;
        cnt_hr  = hr_q;
        if (!dir) begin
            if (sec_q == SEC_MAX) begin
                cnt_sec = '0;
                if (min_q == MIN_MAX) begin
                    cnt_min = '0;
                    cnt_hr  = (hr_q == HR_MAX) ? 5'd0 : hr_q + 5'd1;
                end else begin
                    cnt_min = min_q + 6'd1;
                end
            end else begin
                cnt_sec = sec_q + 6'd1;
            end
        end else begin
            if (sec_q == 6'd0) begin
                cnt_sec = SEC_MAX;
                if (min_q == 6'd0) begin
                    cnt_min = MIN_MAX;
                    cnt_hr  = (hr_q == 5'd0) ? HR_MAX : hr_q - 5'd1;
                end else begin
                    cnt_min = min_q - 6'd1;
                end
            end else begin
                cnt_sec = sec_q - 6'd1;
            end
        end
    end

    // Next-state selection with priority clr > load > tick.
    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        tick_d  = 1'b0;
        alarm_d = 1'b0;
        err_d   = 1'b0;
        if (clr) begin
            presc_d = '0;
            sec_d   = '0;
            min_d   = '0;
            hr_d    = '0;
        end else if (load) begin
            // A load always swallows any tick that lands in the same cycle.
            if (load_ok) begin
                presc_d = '0;
                sec_d   = load_sec;
                min_d   = load_min;
                hr_d    = load_hr;
            end else begin
                err_d   = 1'b1;
            end
        end else begin
            if (run) begin
                presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
            end
            if (tick_int) begin
                sec_d   = cnt_sec;
                min_d   = cnt_min;
                hr_d    = cnt_hr;
                tick_d  = 1'b1;
                alarm_d = alarm_en && alarm_hit;
            end
        end
    end

    // State registers; the tick and alarm strobes update on the same edge as the time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hr_q    <= '0;
            tick_q  <= 1'b0;
            alarm_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            tick_q  <= tick_d;
            alarm_q <= alarm_d;
            err_q   <= err_d;
        end
    end

    assign sec      = sec_q;
    assign min      = min_q;
    assign hr       = hr_q;
    assign tick_sec = tick_q;
    assign alarm    = alarm_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_reloj_hms.sv
// Testbench for reloj_hms with CLK_DIV=4, HOUR_MOD=24: a table of
// load/count vectors plus hand-written multi-cycle sequences.
module tb_reloj_hms;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, clr, dir, load, alarm_en;
    logic [5:0] load_sec, load_min, alarm_sec, alarm_min;
    logic [4:0] load_hr, alarm_hr;
    logic [5:0] sec, min;
    logic [4:0] hr;
    logic       tick_sec, alarm, load_err;

    int total = 0;
    int bad   = 0;

    reloj_hms #(.CLK_DIV(4), .HOUR_MOD(24)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .dir(dir), .load(load),
        .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
        .alarm_en(alarm_en), .alarm_sec(alarm_sec), .alarm_min(alarm_min), .alarm_hr(alarm_hr),
        .sec(sec), .min(min), .hr(hr),
        .tick_sec(tick_sec), .alarm(alarm), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] ld_sec;
        logic [5:0] ld_min;
        logic [4:0] ld_hr;
        logic       ld_dir;
        int         ticks;
        logic [5:0] exp_sec;
        logic [5:0] exp_min;
        logic [4:0] exp_hr;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        load_hr = h; load_min = m; load_sec = s; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    function automatic logic [16:0] hms(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        return {h, m, s};
    endfunction

    initial begin
        //         sec    min    hr     dir  ticks  esec   emin   ehr
        vecs[0] = '{6'd58, 6'd59, 5'd23, 1'b0, 2, 6'd0,  6'd0,  5'd0 };
        vecs[1] = '{6'd59, 6'd59, 5'd23, 1'b0, 1, 6'd0,  6'd0,  5'd0 };
        vecs[2] = '{6'd1,  6'd0,  5'd0,  1'b1, 1, 6'd0,  6'd0,  5'd0 };
        vecs[3] = '{6'd1,  6'd0,  5'd0,  1'b1, 2, 6'd59, 6'd59, 5'd23};
        vecs[4] = '{6'd59, 6'd59, 5'd12, 1'b0, 1, 6'd0,  6'd0,  5'd13};
        vecs[5] = '{6'd0,  6'd0,  5'd10, 1'b1, 1, 6'd59, 6'd59, 5'd9 };
        vecs[6] = '{6'd0,  6'd59, 5'd0,  1'b1, 1, 6'd59, 6'd58, 5'd0 };
        vecs[7] = '{6'd20, 6'd10, 5'd5,  1'b0, 3, 6'd23, 6'd10, 5'd5 };

        rst_n = 1'b0; run = 1'b0; clr = 1'b0; dir = 1'b0; load = 1'b0; alarm_en = 1'b0;
        load_sec = '0; load_min = '0; load_hr = '0;
        alarm_sec = '0; alarm_min = '0; alarm_hr = '0;
        #12 rst_n = 1'b1;
        #1;
        check("reset_outputs", {sec, min, hr, tick_sec, alarm, load_err}, 32'd0);

        // Free run from reset: ticks on cycles 4, 8, 12.
        run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("run_tick_c%0d", i + 1), tick_sec, (i % 4 == 3));
            check($sformatf("run_sec_c%0d", i + 1), sec, (i + 1) / 4);
            check($sformatf("run_quiet_c%0d", i + 1), {min, hr, alarm, load_err}, 32'd0);
        end
        run = 1'b0;

        // Table: load, then count a number of ticks in a direction.
        foreach (vecs[k]) begin
            do_load(vecs[k].ld_hr, vecs[k].ld_min, vecs[k].ld_sec);
            check($sformatf("vec%0d_loaded", k), {load_err, hms(hr, min, sec)},
                  {1'b0, hms(vecs[k].ld_hr, vecs[k].ld_min, vecs[k].ld_sec)});
            dir = vecs[k].ld_dir;
            run = 1'b1;
            for (int c = 0; c < vecs[k].ticks * 4; c++) step();
            run = 1'b0;
            check($sformatf("vec%0d_time", k), hms(hr, min, sec),
                  hms(vecs[k].exp_hr, vecs[k].exp_min, vecs[k].exp_sec));
            check($sformatf("vec%0d_tick", k), tick_sec, 1'b1);
        end
        dir = 1'b0;

        // Rejected load keeps time and prescaler.
        do_load(5'd5, 6'd10, 6'd20);
        run = 1'b1;
        step(); step();                          // prescaler now 2
        load_hr = 5'd5; load_min = 6'd10; load_sec = 6'd60; load = 1'b1;
        step();
        load = 1'b0;
        check("bad_sec_err", load_err, 1'b1);
        check("bad_sec_time", hms(hr, min, sec), hms(5'd5, 6'd10, 6'd20));
        check("bad_sec_notick", tick_sec, 1'b0);
        step();
        check("bad_sec_err_clear", {load_err, tick_sec}, 2'b00);
        step();
        check("bad_sec_presc_kept", {tick_sec, sec}, {1'b1, 6'd21});
        run = 1'b0;
        load_hr = 5'd24; load_min = 6'd0; load_sec = 6'd0; load = 1'b1;
        step();
        check("bad_hr_err1", load_err, 1'b1);
        step();
        check("bad_hr_err2_held", load_err, 1'b1);
        load = 1'b0;
        load_hr = 5'd1; load_min = 6'd60; load = 1'b1;
        step();
        load = 1'b0;
        check("bad_min_err", {load_err, hms(hr, min, sec)}, {1'b1, hms(5'd5, 6'd10, 6'd21)});

        // Alarm on tick arrival at 00:00:03 only.
        clr = 1'b1; step(); clr = 1'b0;
        alarm_en = 1'b1; alarm_hr = 5'd0; alarm_min = 6'd0; alarm_sec = 6'd3;
        run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("alarm_c%0d", i + 1), alarm, (i == 11));
        end
        check("alarm_sec", sec, 6'd3);
        run = 1'b0;
        do_load(5'd0, 6'd0, 6'd3);
        check("alarm_not_by_load", alarm, 1'b0);
        alarm_sec = 6'd61;
        do_load(5'd0, 6'd1, 6'd0);
        alarm_sec = 6'd1; alarm_min = 6'd1;
        run = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("alarm_hit_min", {alarm, tick_sec, min, sec}, {1'b1, 1'b1, 6'd1, 6'd1});
        run = 1'b0;
        alarm_en = 1'b0;

        // Pause for 7 cycles at prescaler 2 delays the tick by exactly 7.
        clr = 1'b1; step(); clr = 1'b0;
        run = 1'b1;
        step(); step();
        run = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check($sformatf("pause_c%0d", i + 1), {tick_sec, sec}, 7'd0);
        end
        run = 1'b1;
        step();
        check("pause_resume_pre", tick_sec, 1'b0);
        step();
        check("pause_resume_tick", {tick_sec, sec}, {1'b1, 6'd1});

        // clr wins over a coincident tick, and over load.
        step(); step(); step();                  // prescaler now 3
        clr = 1'b1;
        step();
        check("clr_over_tick", {tick_sec, hms(hr, min, sec)}, 18'd0);
        load_hr = 5'd5; load_min = 6'd5; load_sec = 6'd5; load = 1'b1;
        step();
        check("clr_over_load", {load_err, hms(hr, min, sec)}, 18'd0);
        clr = 1'b0; load = 1'b0;
        step(); step(); step();
        check("clr_presc_zero_pre", tick_sec, 1'b0);
        step();
        check("clr_presc_zero_tick", {tick_sec, sec}, {1'b1, 6'd1});
        run = 1'b0;

        // Asynchronous reset mid-count.
        do_load(5'd5, 6'd10, 6'd20);
        run = 1'b1;
        step(); step();
        #3 rst_n = 1'b0;
        #1;
        check("async_reset", {sec, min, hr, tick_sec, alarm, load_err}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step(); step(); step();
        check("post_reset_pre", {tick_sec, sec}, 7'd0);
        step();
        check("post_reset_tick", {tick_sec, sec}, {1'b1, 6'd1});
        run = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
